// File: rtl/hour_counter_12_24_if.sv
// Signal bundle for the hour counter: minute tick, set buttons, load port and display outputs.
// The master drives tick/buttons/load/mode; the slave (the counter) drives the hour outputs.
interface hour_counter_12_24_if;
  logic       tick;
  logic       btn_inc;
  logic       btn_dec;
  logic       load;
  logic [4:0] load_hour;
  logic       mode_24h;
  logic [4:0] hour24;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic       pm;
  logic       day_carry;

  modport master (
    output tick,
    output btn_inc,
    output btn_dec,
    output load,
    output load_hour,
    output mode_24h,
    input  hour24,
    input  hr_tens,
    input  hr_ones,
    input  pm,
    input  day_carry
  );

  modport slave (
    input  tick,
    input  btn_inc,
    input  btn_dec,
    input  load,
    input  load_hour,
    input  mode_24h,
    output hour24,
    output hr_tens,
    output hr_ones,
    output pm,
    output day_carry
  );
endinterface

// File: rtl/hour_counter_12_24.sv
// Hour-of-day counter (0..23) with tick advance, synchronised up/down set buttons, direct load,
// 12 h / 24 h BCD display mapping and a registered day-carry pulse.
module hour_counter_12_24 #(
  parameter int unsigned RESET_HOUR  = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          BTN_ACT_LOW = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  hour_counter_12_24_if.slave  bus
);

  localparam logic [4:0] ResetHour = 5'(RESET_HOUR);
  localparam logic [4:0] MaxHour   = 5'd23;

  logic [4:0] hour24_q, hour24_d;
  logic       day_carry_q, day_carry_d;

  logic                   inc_level, dec_level;
  logic [SYNC_STAGES-1:0] inc_sync_q, dec_sync_q;
  logic                   inc_last_q, dec_last_q;
  logic                   inc_e, dec_e;

  logic [5:0] sum_up;
  logic [5:0] sum_net;
  logic       wrap_down;

  logic [4:0] hour_mod12;
  logic [4:0] disp;

  // Normalise polarity before synchronising so all flops reset to the inactive level.
  assign inc_level = bus.btn_inc ^ BTN_ACT_LOW;
  assign dec_level = bus.btn_dec ^ BTN_ACT_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_sync_q <= '0;
      dec_sync_q <= '0;
      inc_last_q <= 1'b0;
      dec_last_q <= 1'b0;
    end else begin
      inc_sync_q <= {inc_sync_q[SYNC_STAGES-2:0], inc_level};
      dec_sync_q <= {dec_sync_q[SYNC_STAGES-2:0], dec_level};
      inc_last_q <= inc_sync_q[SYNC_STAGES-1];
      dec_last_q <= dec_sync_q[SYNC_STAGES-1];
    end
  end

  assign inc_e = inc_sync_q[SYNC_STAGES-1] & ~inc_last_q;
  assign dec_e = dec_sync_q[SYNC_STAGES-1] & ~dec_last_q;

  // Upward contributions first, then the optional decrement; only 0 - 1 can underflow.
  always_comb begin
    sum_up    = {1'b0, hour24_q} + 6'(bus.tick) + 6'(inc_e);
    sum_net   = sum_up - 6'(dec_e);
    wrap_down = dec_e && (sum_up == 6'd0);
  end

  always_comb begin
    hour24_d    = hour24_q;
    day_carry_d = 1'b0;
    if (bus.load) begin
      if (bus.load_hour <= MaxHour) begin
        hour24_d = bus.load_hour;
      end
    end else if (wrap_down) begin
      hour24_d = MaxHour;
    end else if (sum_net >= 6'd24) begin
      hour24_d    = 5'(sum_net - 6'd24);
      day_carry_d = bus.tick;
    end else begin
      hour24_d = sum_net[4:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour24_q    <= ResetHour;
      day_carry_q <= 1'b0;
    end else begin
      hour24_q    <= hour24_d;
      day_carry_q <= day_carry_d;
    end
  end

  // Display mapping is purely combinational so a mode change re-maps in the same cycle.
  always_comb begin
    hour_mod12 = (hour24_q >= 5'd12) ? (hour24_q - 5'd12) : hour24_q;
    if (bus.mode_24h) begin
      disp = hour24_q;
    end else begin
      disp = (hour_mod12 == 5'd0) ? 5'd12 : hour_mod12;
    end
  end

  always_comb begin
    if (disp >= 5'd20) begin
      bus.hr_tens = 4'd2;
      bus.hr_ones = 4'(disp - 5'd20);
    end else if (disp >= 5'd10) begin
      bus.hr_tens = 4'd1;
      bus.hr_ones = 4'(disp - 5'd10);
    end else begin
      bus.hr_tens = 4'd0;
      bus.hr_ones = 4'(disp);
    end
  end

  assign bus.hour24    = hour24_q;
  assign bus.pm        = (hour24_q >= 5'd12);
  assign bus.day_carry = day_carry_q;

endmodule

// File: tb/tb_hour_counter_12_24.sv
// Directed self-checking bench for hour_counter_12_24 with default parameters
// (RESET_HOUR = 0, SYNC_STAGES = 2, active-high buttons).
module tb_hour_counter_12_24;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hour_counter_12_24_if bus ();

  hour_counter_12_24 #(
    .RESET_HOUR (0),
    .SYNC_STAGES(2),
    .BTN_ACT_LOW(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] h);
    bus.load      = 1'b1;
    bus.load_hour = h;
    step();
    bus.load      = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.tick     = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    bus.load     = 1'b0;
    bus.load_hour = 5'd0;
    bus.mode_24h = 1'b0;
    #2;
    checks++;
    if (bus.hour24 !== 5'd0) begin
      errors++; $display("FAIL reset_hour24: got %0d expected 0", bus.hour24);
    end
    checks++;
    if (bus.hr_tens !== 4'd1 || bus.hr_ones !== 4'd2) begin
      errors++; $display("FAIL reset_12h_digits: got %0d%0d expected 12", bus.hr_tens, bus.hr_ones);
    end
    checks++;
    if (bus.pm !== 1'b0) begin
      errors++; $display("FAIL reset_pm: got %0b expected 0", bus.pm);
    end
    checks++;
    if (bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL reset_day_carry: got %0b expected 0", bus.day_carry);
    end
    step();
    step();
    reset = 1'b0;
    bus.mode_24h = 1'b1;
    #1;
    checks++;
    if (bus.hr_tens !== 4'd0 || bus.hr_ones !== 4'd0) begin
      errors++; $display("FAIL reset_24h_digits: got %0d%0d expected 00", bus.hr_tens, bus.hr_ones);
    end
  endtask

  task automatic test_tick_load();
    bus.mode_24h = 1'b0;
    do_load(5'd11);
    checks++;
    if (bus.hour24 !== 5'd11 || bus.hr_tens !== 4'd1 || bus.hr_ones !== 4'd1 || bus.pm !== 1'b0)
    begin
      errors++; $display("FAIL load_11: got %0d (%0d%0d pm %0b) expected 11 (11 pm 0)",
                         bus.hour24, bus.hr_tens, bus.hr_ones, bus.pm);
    end
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd12 || bus.hr_tens !== 4'd1 || bus.hr_ones !== 4'd2 || bus.pm !== 1'b1)
    begin
      errors++; $display("FAIL tick_to_12_12h: got %0d (%0d%0d pm %0b) expected 12 (12 pm 1)",
                         bus.hour24, bus.hr_tens, bus.hr_ones, bus.pm);
    end
    bus.mode_24h = 1'b1;
    #1;
    checks++;
    if (bus.hr_tens !== 4'd1 || bus.hr_ones !== 4'd2) begin
      errors++; $display("FAIL tick_to_12_24h: got %0d%0d expected 12", bus.hr_tens, bus.hr_ones);
    end
    do_load(5'd13);
    checks++;
    if (bus.hr_tens !== 4'd1 || bus.hr_ones !== 4'd3) begin
      errors++; $display("FAIL h13_24h: got %0d%0d expected 13", bus.hr_tens, bus.hr_ones);
    end
    bus.mode_24h = 1'b0;
    #1;
    checks++;
    if (bus.hr_tens !== 4'd0 || bus.hr_ones !== 4'd1 || bus.pm !== 1'b1) begin
      errors++; $display("FAIL h13_12h: got %0d%0d pm %0b expected 01 pm 1",
                         bus.hr_tens, bus.hr_ones, bus.pm);
    end
    bus.mode_24h = 1'b1;
    do_load(5'd23);
    checks++;
    if (bus.hr_tens !== 4'd2 || bus.hr_ones !== 4'd3) begin
      errors++; $display("FAIL h23_24h: got %0d%0d expected 23", bus.hr_tens, bus.hr_ones);
    end
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd0 || bus.day_carry !== 1'b1) begin
      errors++; $display("FAIL tick_wrap: got %0d carry %0b expected 0 carry 1",
                         bus.hour24, bus.day_carry);
    end
    step();
    checks++;
    if (bus.day_carry !== 1'b0 || bus.hour24 !== 5'd0) begin
      errors++; $display("FAIL carry_one_cycle: got %0d carry %0b expected 0 carry 0",
                         bus.hour24, bus.day_carry);
    end
  endtask

  task automatic test_btn_dec();
    int   bad;
    logic carry_seen;
    do_load(5'd0);
    bus.btn_dec = 1'b1;
    step();
    checks++;
    if (bus.hour24 !== 5'd0) begin
      errors++; $display("FAIL dec_edge1: got %0d expected 0", bus.hour24);
    end
    step();
    checks++;
    if (bus.hour24 !== 5'd0) begin
      errors++; $display("FAIL dec_edge2: got %0d expected 0", bus.hour24);
    end
    step();
    checks++;
    if (bus.hour24 !== 5'd23 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL dec_edge3: got %0d carry %0b expected 23 carry 0",
                         bus.hour24, bus.day_carry);
    end
    bad = 0;
    carry_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.hour24 !== 5'd23) bad++;
      if (bus.day_carry !== 1'b0) carry_seen = 1'b1;
    end
    checks++;
    if (bad != 0 || carry_seen) begin
      errors++; $display("FAIL dec_held_once: got %0d (%0d off-value cycles, carry %0b) expected 23",
                         bus.hour24, bad, carry_seen);
    end
    bus.btn_dec = 1'b0;
    repeat (4) step();
    // Upward user wrap 23 -> 0 must not raise day_carry.
    bus.btn_inc = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.hour24 !== 5'd0 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL inc_user_wrap: got %0d carry %0b expected 0 carry 0",
                         bus.hour24, bus.day_carry);
    end
    bus.btn_inc = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_tick_with_buttons();
    do_load(5'd22);
    bus.btn_inc = 1'b1;
    step();
    step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd0 || bus.day_carry !== 1'b1) begin
      errors++; $display("FAIL tick_inc_22: got %0d carry %0b expected 0 carry 1",
                         bus.hour24, bus.day_carry);
    end
    bus.btn_inc = 1'b0;
    repeat (4) step();

    do_load(5'd23);
    bus.btn_inc = 1'b1;
    step();
    step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd1 || bus.day_carry !== 1'b1) begin
      errors++; $display("FAIL tick_inc_23: got %0d carry %0b expected 1 carry 1",
                         bus.hour24, bus.day_carry);
    end
    bus.btn_inc = 1'b0;
    repeat (4) step();

    do_load(5'd5);
    bus.btn_inc = 1'b1;
    bus.btn_dec = 1'b1;
    step();
    step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd6 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL tick_inc_dec_5: got %0d carry %0b expected 6 carry 0",
                         bus.hour24, bus.day_carry);
    end
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_bad_load();
    bus.tick = 1'b1;
    do_load(5'd24);
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd6 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL load_24_tick: got %0d carry %0b expected 6 carry 0",
                         bus.hour24, bus.day_carry);
    end
    do_load(5'd31);
    checks++;
    if (bus.hour24 !== 5'd6) begin
      errors++; $display("FAIL load_31: got %0d expected 6", bus.hour24);
    end
    // A valid load beats a simultaneous tick at 23.
    bus.tick = 1'b1;
    do_load(5'd23);
    bus.tick = 1'b0;
    checks++;
    if (bus.hour24 !== 5'd23 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL load_23_tick: got %0d carry %0b expected 23 carry 0",
                         bus.hour24, bus.day_carry);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_load(5'd7);
    bus.btn_inc = 1'b1;
    step();
    checks++;
    if (bus.hour24 !== 5'd7) begin
      errors++; $display("FAIL pre_reset: got %0d expected 7", bus.hour24);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.hour24 !== 5'd0 || bus.day_carry !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %0d carry %0b expected 0 carry 0",
                         bus.hour24, bus.day_carry);
    end
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.hour24 !== 5'd0) begin
      errors++; $display("FAIL post_reset_wait: got %0d expected 0", bus.hour24);
    end
    step();
    checks++;
    if (bus.hour24 !== 5'd1) begin
      errors++; $display("FAIL post_reset_step: got %0d expected 1", bus.hour24);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.hour24 !== 5'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_once: got %0d (%0d off-value cycles) expected 1",
                         bus.hour24, bad);
    end
    bus.btn_inc = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_tick_load();
    test_btn_dec();
    test_tick_with_buttons();
    test_bad_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
